sc_register_point_shift: RTL and testbench

//  Datapath register for the player-car position. It is the responder to the point-control FSM's clear/load/shift commands.

---
 rtl/sc_register_point_shift_pkg.sv | 18 +
 rtl/sc_register_point_shift.sv | 90 +++++++++
 tb/tb_sc_register_point_shift.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sc_register_point_shift_pkg.sv
// Shared definitions for the player-car position register
// and the point-control FSM that commands it.
package sc_register_point_shift_pkg;

    // Shift-selection encoding driven by the point-control FSM.
    typedef enum logic [1:0] {
        SHIFT_NONE  = 2'b00,
        SHIFT_LEFT  = 2'b01,
        SHIFT_RIGHT = 2'b10,
        SHIFT_HOLD  = 2'b11
    } shift_sel_e;

    // Default geometry of the lane register.
    localparam int          DEF_WIDTH     = 8;
    localparam logic [7:0]  DEF_INIT_POS  = 8'b0001_0000;
    localparam int          DEF_CNT_WIDTH = 8;

endpackage

// File: rtl/sc_register_point_shift.sv
// One-hot player-car position register with edge detection,
// refused-shift pulse and a saturating accepted-move counter.
module sc_register_point_shift
    import sc_register_point_shift_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] INIT_POS  = WIDTH'(DEF_INIT_POS),
    parameter int               CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic                 SC_STATEMACHINEPOINT_RESET_InHigh,
    input  logic                 SC_REGPOINT_clear_InLow,
    input  logic                 SC_REGPOINT_load_InLow,
    input  logic [1:0]           SC_REGPOINT_shiftselection_In,
    output logic [WIDTH-1:0]     SC_REGPOINT_data_OutBUS,
    output logic                 SC_REGPOINT_sidecomparator_OutLow,
    output logic                 SC_REGPOINT_blocked_OutHigh,
    output logic [CNT_WIDTH-1:0] SC_REGPOINT_moves_OutBUS
);

    logic [WIDTH-1:0]     data;
    logic [WIDTH-1:0]     data_next;
    logic [CNT_WIDTH-1:0] moves;
    logic [CNT_WIDTH-1:0] moves_next;
    logic [CNT_WIDTH-1:0] moves_sat;
    logic                 blocked;
    logic                 blocked_next;
    logic                 can_left;
    logic                 can_right;

    // A shift is only legal from a loaded position not already at that edge.
    assign can_left  = (data != '0) && !data[WIDTH-1];
    assign can_right = (data != '0) && !data[0];

    // Counter sticks at all-ones; the position still moves once saturated.
    assign moves_sat = (moves == '1) ? moves : moves + CNT_WIDTH'(1);

    // Next-state decode: clear beats load beats shift beats hold.
    always_comb begin
        data_next    = data;
        moves_next   = moves;
        blocked_next = 1'b0;
        if (!SC_REGPOINT_clear_InLow) begin
            data_next  = '0;
            moves_next = '0;
        end else if (!SC_REGPOINT_load_InLow) begin
            data_next = INIT_POS;
        end else begin
            case (shift_sel_e'(SC_REGPOINT_shiftselection_In))
                SHIFT_LEFT: begin
                    if (can_left) begin
                        data_next  = data << 1;
                        moves_next = moves_sat;
                    end else begin
                        blocked_next = 1'b1;
                    end
                end
                SHIFT_RIGHT: begin
                    if (can_right) begin
                        data_next  = data >> 1;
                        moves_next = moves_sat;
                    end else begin
                        blocked_next = 1'b1;
                    end
                end
                default: blocked_next = 1'b0;
            endcase
        end
    end

    // State register; reset forces the unloaded, zero-count state at once.
    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50
                or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            data    <= '0;
            moves   <= '0;
            blocked <= 1'b0;
        end else begin
            data    <= data_next;
            moves   <= moves_next;
            blocked <= blocked_next;
        end
    end

    assign SC_REGPOINT_data_OutBUS           = data;
    assign SC_REGPOINT_moves_OutBUS          = moves;
    assign SC_REGPOINT_blocked_OutHigh       = blocked;
    assign SC_REGPOINT_sidecomparator_OutLow = ~(data[WIDTH-1] | data[0]);

endmodule

// File: tb/tb_sc_register_point_shift.sv
// Scoreboard bench: lane-index reference model feeds an expected queue,
// a monitor pops one entry per clock and compares both DUT instances.
module tb_sc_register_point_shift;

    logic       clk;
    logic       rst;
    logic       clr_n;
    logic       ld_n;
    logic [1:0] sel;

    logic [7:0] data;
    logic       side;
    logic       blk;
    logic [7:0] moves;

    logic [7:0] data2;
    logic       side2;
    logic       blk2;
    logic [1:0] moves2;

    typedef struct {
        logic [7:0] data;
        logic       side;
        logic       blk;
        logic [7:0] mv8;
        logic [1:0] mv2;
    } exp_t;

    exp_t q[$];

    int tests;
    int fails;

    // model state: lane index of the car, -1 when unloaded
    int pos;
    int m8;
    int m2;
    bit mblk;

    sc_register_point_shift u_dut (
        .SC_STATEMACHINEPOINT_CLOCK_50    (clk),
        .SC_STATEMACHINEPOINT_RESET_InHigh(rst),
        .SC_REGPOINT_clear_InLow          (clr_n),
        .SC_REGPOINT_load_InLow           (ld_n),
        .SC_REGPOINT_shiftselection_In    (sel),
        .SC_REGPOINT_data_OutBUS          (data),
        .SC_REGPOINT_sidecomparator_OutLow(side),
        .SC_REGPOINT_blocked_OutHigh      (blk),
        .SC_REGPOINT_moves_OutBUS         (moves)
    );

    sc_register_point_shift #(.CNT_WIDTH(2)) u_dut2 (
        .SC_STATEMACHINEPOINT_CLOCK_50    (clk),
        .SC_STATEMACHINEPOINT_RESET_InHigh(rst),
        .SC_REGPOINT_clear_InLow          (clr_n),
        .SC_REGPOINT_load_InLow           (ld_n),
        .SC_REGPOINT_shiftselection_In    (sel),
        .SC_REGPOINT_data_OutBUS          (data2),
        .SC_REGPOINT_sidecomparator_OutLow(side2),
        .SC_REGPOINT_blocked_OutHigh      (blk2),
        .SC_REGPOINT_moves_OutBUS         (moves2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.data = (pos < 0) ? 8'h00 : 8'(1 << pos);
        e.side = !(pos == 0 || pos == 7);
        e.blk  = mblk;
        e.mv8  = 8'(m8);
        e.mv2  = 2'(m2);
        return e;
    endfunction

    // Apply one command cycle: drive pins, advance model, queue expectation.
    task automatic step(input logic r, input logic c, input logic l,
                        input logic [1:0] s);
        @(negedge clk);
        rst   = r;
        clr_n = c;
        ld_n  = l;
        sel   = s;
        if (r) begin
            pos = -1; m8 = 0; m2 = 0; mblk = 0;
        end else if (!c) begin
            pos = -1; m8 = 0; m2 = 0; mblk = 0;
        end else if (!l) begin
            pos = 4; mblk = 0;
        end else if (s == 2'b01) begin
            if (pos >= 0 && pos < 7) begin
                pos++;
                m8 = (m8 < 255) ? m8 + 1 : 255;
                m2 = (m2 < 3) ? m2 + 1 : 3;
                mblk = 0;
            end else begin
                mblk = 1;
            end
        end else if (s == 2'b10) begin
            if (pos > 0) begin
                pos--;
                m8 = (m8 < 255) ? m8 + 1 : 255;
                m2 = (m2 < 3) ? m2 + 1 : 3;
                mblk = 0;
            end else begin
                mblk = 1;
            end
        end else begin
            mblk = 0;
        end
        q.push_back(model_out());
        if (r) begin
            #1;
            chk("rst_async_data", 32'(data), 32'h0);
            chk("rst_async_moves", 32'(moves), 32'h0);
            chk("rst_async_blk", 32'(blk), 32'h0);
            chk("rst_async_side", 32'(side), 32'h1);
        end
    endtask

    // Monitor: one expected entry per clock once stimulus has begun.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("data", 32'(data), 32'(e.data));
            chk("side", 32'(side), 32'(e.side));
            chk("blocked", 32'(blk), 32'(e.blk));
            chk("moves", 32'(moves), 32'(e.mv8));
            chk("onehot", 32'($onehot0(data)), 32'h1);
            chk("data_c2", 32'(data2), 32'(e.data));
            chk("blocked_c2", 32'(blk2), 32'(e.blk));
            chk("moves_c2", 32'(moves2), 32'(e.mv2));
            chk("side_c2", 32'(side2), 32'(e.side));
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        pos   = -1;
        m8    = 0;
        m2    = 0;
        mblk  = 0;
        rst   = 1'b1;
        clr_n = 1'b1;
        ld_n  = 1'b1;
        sel   = 2'b00;

        step(1, 1, 1, 2'b00);
        // T1: reset in the middle of shifting
        step(0, 1, 0, 2'b00);
        step(0, 1, 1, 2'b01);
        step(1, 1, 1, 2'b01);
        step(0, 1, 1, 2'b00);
        // T2: clear wins over load, then load alone
        step(0, 0, 0, 2'b01);
        step(0, 1, 0, 2'b00);
        // T3: left to the MSB edge and one refused
        repeat (4) step(0, 1, 1, 2'b01);
        step(0, 1, 1, 2'b11);
        // T4: right across to the LSB edge and one refused
        repeat (8) step(0, 1, 1, 2'b10);
        step(0, 1, 1, 2'b00);
        // T5: shifts while unloaded are refused
        step(0, 0, 1, 2'b00);
        step(0, 1, 1, 2'b01);
        step(0, 1, 1, 2'b10);
        step(0, 1, 1, 2'b00);
        // T6: small counter saturates while data keeps moving
        step(0, 1, 0, 2'b00);
        repeat (3) step(0, 1, 1, 2'b01);
        repeat (2) step(0, 1, 1, 2'b10);
        step(0, 1, 1, 2'b10);

        for (int i = 0; i < 600; i++) begin
            step(($urandom % 64) == 0,
                 ($urandom % 20) != 0,
                 ($urandom % 10) != 0,
                 2'($urandom));
        end
        step(0, 1, 1, 2'b00);

        repeat (2) @(posedge clk);
        #4;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
